// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator wrapped around an external combinational
// 1-bit comparator cell; exits at the first differing bit and reports a one-hot result.
//
// state | meaning
// IDLE  | waiting for start; previous result held on gt/eq/lt/err
// SHIFT | presenting a_reg[idx]/b_reg[idx] to the cell and sampling its flags
// DONE  | done pulse; result valid
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             a_bit,
    output logic             b_bit,
    input  logic             bit_g,
    input  logic             bit_e,
    input  logic             bit_s,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             err
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_reg_q, a_reg_d;
    logic [WIDTH-1:0] b_reg_q, b_reg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_reg_q <= '0;
            b_reg_q <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_reg_q <= a_reg_d;
            b_reg_q <= b_reg_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_reg_d = a_reg_q;
        b_reg_d = b_reg_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_reg_d = a_word;
                    b_reg_d = b_word;
                    idx_d   = IW'(WIDTH - 1);
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // anything other than exactly one flag means the cell is broken
                case ({bit_g, bit_e, bit_s})
                    3'b100: begin
                        gt_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                    3'b001: begin
                        lt_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                    3'b010: begin
                        if (idx_q == '0) begin
                            eq_d    = 1'b1;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            idx_d = idx_q - IW'(1);
                        end
                    end
                    default: begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign a_bit = a_reg_q[idx_q];
    assign b_bit = b_reg_q[idx_q];
    assign busy  = (state_q == S_SHIFT);
    assign done  = done_q;
    assign gt    = gt_q;
    assign eq    = eq_q;
    assign lt    = lt_q;
    assign err   = err_q;

endmodule
